spi_top_core: RTL and testbench
===============================

# spi_top_core

Minimal SPI-loadable compute tile: an SPI slave writes and reads a 1 KiB word RAM, and a small multicycle RV32E-subset core executes from that RAM. The core publishes results through a 32-bit GPIO output register. The block is the top of the test tile; it is loaded over SPI while halted, then started by `fetch_enable_i`.

## Interface
- No parameters. RAM is 256×32, boot PC is 0x80, and the GPIO address is 0x1000_0000, all fixed.
- `clk_i` in 1: single clock, rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `fetch_enable_i` in 1: core run enable. Low forces the core to IDLE.
- `en_ifetch_i` in 1: instruction-fetch gate. Low stalls the core in FETCH.
- `spi_sclk` in 1: SPI clock, asynchronous to `clk_i`.
- `spi_cs` in 1: SPI chip select, active-low.
- `spi_mode` out 2: constant 2'b00 (standard single-bit mode).
- `spi_sdi0..3` in 1 each: only `spi_sdi0` is used.
- `spi_sdo0..3` out 1 each: read data on `spi_sdo0`. `spi_sdo1..3` are tied to 0.
- `gpio_o` out 32: GPIO output register.

## Operation
**SPI front end**
- `spi_sclk`, `spi_cs` and `spi_sdi0` are each synchronized with 2 flops. The SCLK rising edge is detected in the `clk_i` domain.
- SCLK high and low phases must each be ≥4 `clk_i` periods.
- Frame format, MSB first, sampled on SCLK rise while `spi_cs`=0: 8-bit cmd, then 32-bit addr, then 32-bit data.
- cmd 0x02 (write): the RAM word at addr[9:2] is written when the 72nd bit is captured. It is ignored if addr[31:10]≠0.
- cmd 0x0B (read): after bit 40, the word at addr[9:2] is shifted out on `spi_sdo0`, MSB first. Bits change on SCLK fall and are valid for the next 32 rises.
- Any other cmd: the rest of the frame is ignored.
- `spi_cs` rising before a frame completes discards the frame, with no write. The bit counter resets whenever `spi_cs`=1.

**RAM**
- Single port, synchronous read with 1-cycle latency. Contents are not affected by reset.
- SPI access has priority over the core. The core's memory state stalls for one cycle on a conflict.

**Core**
- Register file: x0–x15, with x0 hard-wired to 0.
- Instructions: LUI, ADDI, ADD, SUB, SLLI, LW, SW, BEQ, BNE, BLT, JAL, and MUL when configured (see Configuration).
- Word 0x00000FFF is HALT.
- Any other encoding, or a register index >15, also halts the core.
- Core memory map:
  - 0x000–0x3FF: RAM.
  - 0x1000_0000: GPIO. SW writes `gpio_o`; LW reads back `gpio_o`.
  - Anything else: loads return 0, stores are dropped.
  - Address bits [1:0] are ignored.
- FSM states:
  - IDLE: PC=0x80. Goes to FETCH when `fetch_enable_i`=1.
  - FETCH: issues the RAM read at PC. Holds while `en_ifetch_i`=0.
  - DECODE: latches the instruction and reads registers.
  - EXEC: ALU and branch. ALU ops write back here, and next is FETCH. LW/SW go to MEM. HALT or illegal goes to HALT.
  - MEM: load read or store.
  - WB: load writeback, then FETCH.
  - HALT: holds until `fetch_enable_i`=0.
- `fetch_enable_i`=0 in any state returns the core to IDLE on the next edge. Registers and `gpio_o` are retained.
- Arithmetic is 32-bit two's complement, wrap-around. MUL returns the low 32 bits of the product.
- Branch and JAL targets are PC-relative.

## Timing
- Reset values: `gpio_o`=0, `spi_sdo0..3`=0, `spi_mode`=00, PC=0x80, x1–x15=0, FSM=IDLE, SPI counter=0.
- ALU and branch instructions take 3 cycles: FETCH, DECODE, EXEC.
- SW takes 4 cycles. LW takes 5 cycles.
- A GPIO store is visible on `gpio_o` on the edge ending MEM.
- An SPI write lands in RAM within 3 `clk_i` cycles after the 72nd SCLK rise.
- Reset asserted mid-frame or mid-instruction aborts the operation at once. The RAM keeps its contents.

## Configuration
- `TOP_CORE_MUL_EN` defined: MUL (opcode 0x33, funct7 0x01) is implemented as a single-cycle 32×32 multiply in EXEC.
- `TOP_CORE_MUL_EN` undefined: the MUL encoding is illegal and halts the core. No multiplier is synthesized.

## Test plan
- Reset and idle: after reset, `gpio_o`=0 and `spi_sdo0`=0. With `fetch_enable_i`=0 for 100 cycles, there is no RAM or GPIO activity.
- SPI write/read: write 0xDEADBEEF to 0x84 with cmd 0x02, then cmd 0x0B at 0x84 → `spi_sdo0` shifts 0xDEADBEEF. A write to 0x400 is ignored; reading 0x000 afterwards is unchanged.
- Program ADDI x1,x0,5; ADDI x2,x0,7; MUL x3,x1,x2; SW x3→0x1000_0000; HALT, loaded at 0x80 and started → `gpio_o`=35. Without the macro, `gpio_o`=0 and the core is in HALT.
- Stall: with `en_ifetch_i`=0 after start, PC stays at 0x80 and `gpio_o` is unchanged. Raising it completes the previous program to 35.
- Loop program: a 100-element saxpy image at 0x80 whose result sum is 30001 → `gpio_o`=30001 within 1000 cycles. Dropping `fetch_enable_i` keeps `gpio_o`=30001.
- Aborted frame: `spi_cs` raised after 50 bits → RAM is unchanged and the next full frame writes correctly.

Source files
------------

// File: rtl/spi_top_core.sv
// SPI-loadable 256x32 word RAM plus a multicycle RV32E-subset core publishing results on gpio_o.
// Optional MUL instruction is built in when the macro TOP_CORE_MUL_EN is defined.
module spi_top_core (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        fetch_enable_i,
    input  logic        en_ifetch_i,
    input  logic        spi_sclk,
    input  logic        spi_cs,
    output logic [1:0]  spi_mode,
    input  logic        spi_sdi0,
    input  logic        spi_sdi1,
    input  logic        spi_sdi2,
    input  logic        spi_sdi3,
    output logic        spi_sdo0,
    output logic        spi_sdo1,
    output logic        spi_sdo2,
    output logic        spi_sdo3,
    output logic [31:0] gpio_o
);
    localparam logic [31:0] BOOT_PC   = 32'h0000_0080;
    localparam logic [31:0] GPIO_ADDR = 32'h1000_0000;
    localparam logic [7:0]  CMD_WR    = 8'h02;
    localparam logic [7:0]  CMD_RD    = 8'h0B;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_e;

    logic [1:0]  sclk_sync_q, cs_sync_q, sdi_sync_q;
    logic        sclk_prev_q;
    logic [6:0]  cnt_q;
    logic [30:0] sh_q;
    logic [31:0] sh_d, tx_q;
    logic [7:0]  cmd_q;
    logic [31:2] addr_q;
    logic        rd_vld_q, sdo_q;
    logic        sclk_s, cs_s, sdi_s, sclk_rise, sclk_fall, bit_rise;
    logic        spi_rd_req, spi_wr_req, spi_req;
    logic [7:0]  spi_addr;

    logic [31:0] mem_q [256];
    logic [7:0]  ram_addr;
    logic        ram_we;
    logic [31:0] ram_wdata, ram_rdata_q;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d, ir_q, ir_d;
    logic [31:0] rs1v_q, rs1v_d, rs2v_q, rs2v_d;
    logic [31:2] maddr_q, maddr_d;
    logic [31:0] wdat_q, wdat_d, ld_dat_q, ld_dat_d, gpio_q, gpio_d;
    logic        ld_ram_q, ld_ram_d;
    logic [31:0] rf_q [16];
    logic        rf_we;
    logic [3:0]  rf_wa;
    logic [31:0] rf_wd;
    logic        core_req, core_we;
    logic [7:0]  core_addr;

    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u, ea, res;
    logic        illegal, badreg, alu_wr, take, is_st, ram_hit, gpio_hit;
    logic        unused_ok;

    // ---------------- SPI front end ----------------
    assign sclk_s    = sclk_sync_q[1];
    assign cs_s      = cs_sync_q[1];
    assign sdi_s     = sdi_sync_q[1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign sh_d      = {sh_q, sdi_s};
    assign bit_rise  = sclk_rise & ~cs_s & (cnt_q < 7'd72);
    assign spi_rd_req = bit_rise & (cnt_q == 7'd39) & (cmd_q == CMD_RD);
    assign spi_wr_req = bit_rise & (cnt_q == 7'd71) & (cmd_q == CMD_WR) & (addr_q[31:10] == '0);
    assign spi_req    = spi_rd_req | spi_wr_req;
    // A read uses the address bits arriving on this very edge, a write the latched address.
    assign spi_addr   = spi_rd_req ? sh_d[9:2] : addr_q[9:2];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= 2'b11;
            sdi_sync_q  <= '0;
            sclk_prev_q <= 1'b0;
            cnt_q       <= '0;
            sh_q        <= '0;
            tx_q        <= '0;
            cmd_q       <= '0;
            addr_q      <= '0;
            rd_vld_q    <= 1'b0;
            sdo_q       <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[0], spi_sclk};
            cs_sync_q   <= {cs_sync_q[0], spi_cs};
            sdi_sync_q  <= {sdi_sync_q[0], spi_sdi0};
            sclk_prev_q <= sclk_s;
            rd_vld_q    <= spi_rd_req;
            if (cs_s) begin
                cnt_q <= '0;
                sdo_q <= 1'b0;
            end else begin
                if (bit_rise) begin
                    sh_q  <= sh_d[30:0];
                    cnt_q <= cnt_q + 7'd1;
                    if (cnt_q == 7'd7)  cmd_q  <= sh_d[7:0];
                    if (cnt_q == 7'd39) addr_q <= sh_d[31:2];
                end
                if (rd_vld_q) begin
                    tx_q <= ram_rdata_q;
                end else if (sclk_fall && cmd_q == CMD_RD && cnt_q >= 7'd40 && cnt_q < 7'd72) begin
                    sdo_q <= tx_q[31];
                    tx_q  <= {tx_q[30:0], 1'b0};
                end
            end
        end
    end

    // ---------------- RAM (SPI wins over the core) ----------------
    assign ram_addr  = spi_req ? spi_addr : core_addr;
    assign ram_we    = spi_wr_req | (core_req & core_we & ~spi_req);
    assign ram_wdata = spi_wr_req ? sh_d : wdat_q;

    always_ff @(posedge clk_i) begin
        if (ram_we) mem_q[ram_addr] <= ram_wdata;
        ram_rdata_q <= mem_q[ram_addr];
    end

    // ---------------- Core ----------------
    assign opc   = ir_q[6:0];
    assign f3    = ir_q[14:12];
    assign f7    = ir_q[31:25];
    assign imm_i = {{20{ir_q[31]}}, ir_q[31:20]};
    assign imm_s = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
    assign imm_b = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
    assign imm_j = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
    assign imm_u = {ir_q[31:12], 12'b0};
    assign ea    = rs1v_q + (opc == 7'b0100011 ? imm_s : imm_i);
    assign is_st = ir_q[5];
    assign ram_hit  = (maddr_q[31:10] == '0);
    assign gpio_hit = (maddr_q == GPIO_ADDR[31:2]);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        rs1v_d    = rs1v_q;
        rs2v_d    = rs2v_q;
        maddr_d   = maddr_q;
        wdat_d    = wdat_q;
        ld_dat_d  = ld_dat_q;
        ld_ram_d  = ld_ram_q;
        gpio_d    = gpio_q;
        rf_we     = 1'b0;
        rf_wa     = ir_q[10:7];
        rf_wd     = '0;
        core_req  = 1'b0;
        core_we   = 1'b0;
        core_addr = pc_q[9:2];
        illegal   = 1'b0;
        badreg    = 1'b0;
        alu_wr    = 1'b0;
        take      = 1'b0;
        res       = '0;
        case (state_q)
            S_IDLE: begin
                pc_d = BOOT_PC;
                if (fetch_enable_i) state_d = S_FETCH;
            end
            S_FETCH: if (en_ifetch_i) begin
                core_req = 1'b1;
                if (!spi_req) state_d = S_DECODE;
            end
            S_DECODE: begin
                ir_d    = ram_rdata_q;
                rs1v_d  = rf_q[ram_rdata_q[18:15]];
                rs2v_d  = rf_q[ram_rdata_q[23:20]];
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_FETCH;
                pc_d    = pc_q + 32'd4;
                case (opc)
                    7'b0110111: begin alu_wr = 1'b1; res = imm_u; badreg = ir_q[11]; end
                    7'b0010011: begin
                        alu_wr = 1'b1;
                        badreg = ir_q[11] | ir_q[19];
                        if (f3 == 3'b000)                     res = rs1v_q + imm_i;
                        else if (f3 == 3'b001 && f7 == 7'h00) res = rs1v_q << ir_q[24:20];
                        else                                  illegal = 1'b1;
                    end
                    7'b0110011: begin
                        alu_wr = 1'b1;
                        badreg = ir_q[11] | ir_q[19] | ir_q[24];
                        if (f3 != 3'b000)       illegal = 1'b1;
                        else if (f7 == 7'h00)   res = rs1v_q + rs2v_q;
                        else if (f7 == 7'h20)   res = rs1v_q - rs2v_q;
                        else if (f7 == 7'h01) begin
`ifdef TOP_CORE_MUL_EN
                            res = rs1v_q * rs2v_q;
`else
                            illegal = 1'b1;
`endif
                        end else                illegal = 1'b1;
                    end
                    7'b0000011: begin
                        illegal = (f3 != 3'b010);
                        badreg  = ir_q[11] | ir_q[19];
                        maddr_d = ea[31:2];
                        state_d = S_MEM;
                    end
                    7'b0100011: begin
                        illegal = (f3 != 3'b010);
                        badreg  = ir_q[19] | ir_q[24];
                        maddr_d = ea[31:2];
                        wdat_d  = rs2v_q;
                        state_d = S_MEM;
                    end
                    7'b1100011: begin
                        badreg = ir_q[19] | ir_q[24];
                        case (f3)
                            3'b000:  take = (rs1v_q == rs2v_q);
                            3'b001:  take = (rs1v_q != rs2v_q);
                            3'b100:  take = ($signed(rs1v_q) < $signed(rs2v_q));
                            default: illegal = 1'b1;
                        endcase
                        if (take) pc_d = pc_q + imm_b;
                    end
                    7'b1101111: begin
                        alu_wr = 1'b1;
                        badreg = ir_q[11];
                        res    = pc_q + 32'd4;
                        pc_d   = pc_q + imm_j;
                    end
                    default: illegal = 1'b1;
                endcase
                if (illegal || badreg) begin
                    state_d = S_HALT;
                    pc_d    = pc_q;
                end else begin
                    rf_we = alu_wr;
                    rf_wd = res;
                end
            end
            S_MEM: begin
                if (ram_hit) begin
                    core_req  = 1'b1;
                    core_we   = is_st;
                    core_addr = maddr_q[9:2];
                    ld_ram_d  = 1'b1;
                    if (!spi_req) state_d = is_st ? S_FETCH : S_WB;
                end else begin
                    ld_ram_d = 1'b0;
                    ld_dat_d = gpio_hit ? gpio_q : '0;
                    if (is_st && gpio_hit) gpio_d = wdat_q;
                    state_d = is_st ? S_FETCH : S_WB;
                end
            end
            S_WB: begin
                rf_we   = 1'b1;
                rf_wd   = ld_ram_q ? ram_rdata_q : ld_dat_q;
                state_d = S_FETCH;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
        // Dropping run enable aborts whatever is in flight without side effects.
        if (!fetch_enable_i) begin
            state_d  = S_IDLE;
            pc_d     = BOOT_PC;
            core_req = 1'b0;
            core_we  = 1'b0;
            gpio_d   = gpio_q;
            rf_we    = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            pc_q     <= BOOT_PC;
            ir_q     <= '0;
            rs1v_q   <= '0;
            rs2v_q   <= '0;
            maddr_q  <= '0;
            wdat_q   <= '0;
            ld_dat_q <= '0;
            ld_ram_q <= 1'b0;
            gpio_q   <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            rs1v_q   <= rs1v_d;
            rs2v_q   <= rs2v_d;
            maddr_q  <= maddr_d;
            wdat_q   <= wdat_d;
            ld_dat_q <= ld_dat_d;
            ld_ram_q <= ld_ram_d;
            gpio_q   <= gpio_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < 16; i++) rf_q[i] <= '0;
        end else if (rf_we && rf_wa != 4'd0) begin
            rf_q[rf_wa] <= rf_wd;
        end
    end

    assign spi_mode  = 2'b00;
    assign spi_sdo0  = sdo_q;
    assign spi_sdo1  = 1'b0;
    assign spi_sdo2  = 1'b0;
    assign spi_sdo3  = 1'b0;
    assign gpio_o    = gpio_q;
    assign unused_ok = ^{spi_sdi1, spi_sdi2, spi_sdi3, ea[1:0]};
endmodule

// File: tb/tb_spi_top_core.sv
// Directed bench for spi_top_core: SPI load/readback, aborted frames, and three small programs.
module tb_spi_top_core;
    localparam int H = 6;

    logic        clk = 1'b0, rst = 1'b1, fe = 1'b0, efi = 1'b0;
    logic        sclk = 1'b0, cs = 1'b1, sdi0 = 1'b0;
    logic [1:0]  mode;
    logic        sdo0, sdo1, sdo2, sdo3;
    logic [31:0] gpio;
    int          total = 0, bad = 0;

    always #5 clk = ~clk;

    spi_top_core dut (
        .clk_i(clk), .rst_i(rst), .fetch_enable_i(fe), .en_ifetch_i(efi),
        .spi_sclk(sclk), .spi_cs(cs), .spi_mode(mode),
        .spi_sdi0(sdi0), .spi_sdi1(1'b0), .spi_sdi2(1'b0), .spi_sdi3(1'b0),
        .spi_sdo0(sdo0), .spi_sdo1(sdo1), .spi_sdo2(sdo2), .spi_sdo3(sdo3),
        .gpio_o(gpio)
    );

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic spi_xfer(input logic [7:0] cmd, input logic [31:0] addr,
                            input logic [31:0] data, input int nbits, output logic [31:0] rd);
        logic [71:0] fr;
        fr = {cmd, addr, data};
        rd = '0;
        cs = 1'b0;
        cyc(H);
        for (int i = 0; i < nbits; i++) begin
            sdi0 = fr[71-i];
            cyc(H);
            if (i >= 40) rd = {rd[30:0], sdo0};
            sclk = 1'b1;
            cyc(H);
            sclk = 1'b0;
        end
        cyc(H);
        cs = 1'b1;
        cyc(2*H);
    endtask

    task automatic spi_wr(input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] dummy;
        spi_xfer(8'h02, addr, data, 72, dummy);
    endtask

    task automatic spi_rd(input logic [31:0] addr, output logic [31:0] rd);
        spi_xfer(8'h0B, addr, 32'h0, 72, rd);
    endtask

    function automatic logic [31:0] i_t(input int imm, input int rs1, input int f3, input int rd);
        logic [11:0] im;
        im = imm[11:0];
        return {im, rs1[4:0], f3[2:0], rd[4:0], 7'b0010011};
    endfunction
    function automatic logic [31:0] lw_t(input int imm, input int rs1, input int rd);
        logic [11:0] im;
        im = imm[11:0];
        return {im, rs1[4:0], 3'b010, rd[4:0], 7'b0000011};
    endfunction
    function automatic logic [31:0] s_t(input int imm, input int rs1, input int rs2);
        logic [11:0] im;
        im = imm[11:0];
        return {im[11:5], rs2[4:0], rs1[4:0], 3'b010, im[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] r_t(input logic [6:0] f7, input int rs2, input int rs1, input int rd);
        return {f7, rs2[4:0], rs1[4:0], 3'b000, rd[4:0], 7'b0110011};
    endfunction
    function automatic logic [31:0] b_t(input int imm, input int rs1, input int rs2, input int f3);
        logic [12:0] im;
        im = imm[12:0];
        return {im[12], im[10:5], rs2[4:0], rs1[4:0], f3[2:0], im[4:1], im[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] j_t(input int imm, input int rd);
        logic [20:0] im;
        im = imm[20:0];
        return {im[20], im[10:1], im[11], im[19:12], rd[4:0], 7'b1101111};
    endfunction
    function automatic logic [31:0] u_t(input logic [19:0] imm, input int rd);
        return {imm, rd[4:0], 7'b0110111};
    endfunction

    logic [31:0] prog [$];
    logic [31:0] rd;
    logic [31:0] mul_exp;
    int          k;

    task automatic load_prog();
        foreach (prog[i]) spi_wr(32'h80 + 32'(4*i), prog[i]);
    endtask

    initial begin
`ifdef TOP_CORE_MUL_EN
        mul_exp = 32'd35;
`else
        mul_exp = 32'd0;
`endif
        cyc(5);
        rst = 1'b0;
        cyc(2);
        chk("reset_gpio", gpio, 32'h0);
        chk("reset_sdo0", {31'h0, sdo0}, 32'h0);
        chk("reset_sdo123", {29'h0, sdo1, sdo2, sdo3}, 32'h0);
        chk("spi_mode", {30'h0, mode}, 32'h0);
        cyc(100);
        chk("idle_gpio", gpio, 32'h0);

        // SPI write/read, out-of-range write ignored
        spi_wr(32'h84, 32'hDEADBEEF);
        spi_rd(32'h84, rd);
        chk("spi_rd_84", rd, 32'hDEADBEEF);
        spi_wr(32'h000, 32'h12345678);
        spi_wr(32'h400, 32'hCAFEF00D);
        spi_rd(32'h000, rd);
        chk("spi_wr_400_ignored", rd, 32'h12345678);

        // Aborted frame and unknown command leave RAM untouched
        spi_xfer(8'h02, 32'h84, 32'h11111111, 50, rd);
        spi_rd(32'h84, rd);
        chk("abort_no_write", rd, 32'hDEADBEEF);
        spi_xfer(8'h03, 32'h84, 32'h22222222, 72, rd);
        spi_rd(32'h84, rd);
        chk("badcmd_no_write", rd, 32'hDEADBEEF);
        spi_wr(32'h88, 32'h55AA55AA);
        spi_rd(32'h88, rd);
        chk("after_abort_write", rd, 32'h55AA55AA);

        // MUL program, started with fetch stalled
        prog = '{i_t(5, 0, 0, 1), i_t(7, 0, 0, 2), r_t(7'h01, 2, 1, 3),
                 u_t(20'h10000, 4), s_t(0, 4, 3), 32'h00000FFF};
        load_prog();
        efi = 1'b0;
        fe  = 1'b1;
        cyc(50);
        chk("stall_pc", dut.pc_q, 32'h80);
        chk("stall_gpio", gpio, 32'h0);
        efi = 1'b1;
        cyc(100);
        chk("mul_prog_gpio", gpio, mul_exp);
        fe = 1'b0;
        cyc(5);

        // Loads, shifts, SUB, branches, JAL, GPIO readback, dropped store
        spi_wr(32'h200, 32'hDEADBEEF);
        prog = '{u_t(20'h10000, 4), lw_t(32'h200, 0, 5), i_t(3, 0, 0, 6), i_t(4, 6, 1, 6),
                 r_t(7'h20, 6, 5, 7), b_t(8, 0, 6, 4), 32'h00000FFF, j_t(8, 8),
                 32'h00000FFF, r_t(7'h00, 8, 7, 7), s_t(0, 4, 7), lw_t(0, 4, 9),
                 s_t(32'h204, 0, 9), b_t(8, 9, 7, 0), 32'h00000FFF, i_t(-1, 0, 0, 10),
                 s_t(32'h300, 4, 10), 32'h00000FFF};
        load_prog();
        fe = 1'b1;
        cyc(200);
        chk("misc_gpio", gpio, 32'hDEADBF5F);
        fe = 1'b0;
        cyc(5);
        spi_rd(32'h204, rd);
        chk("misc_ram_store", rd, 32'hDEADBF5F);

        // Saxpy-style loop: 1 + sum_{i<100}(6*i + 3) = 30001
        prog = '{i_t(1, 0, 0, 1), i_t(3, 0, 0, 2), i_t(603, 0, 0, 3), r_t(7'h00, 2, 1, 1),
                 i_t(6, 2, 0, 2), b_t(-8, 2, 3, 1), u_t(20'h10000, 4), s_t(0, 4, 1),
                 32'h00000FFF};
        load_prog();
        fe = 1'b1;
        k  = 0;
        while (gpio !== 32'd30001 && k < 1000) begin
            cyc(1);
            k++;
        end
        chk("saxpy_gpio", gpio, 32'd30001);
        fe = 1'b0;
        cyc(20);
        chk("saxpy_hold", gpio, 32'd30001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
